// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the multi-port register file:
//   - default data/address widths
//   - number of write ports and the hard-wired zero register address
//   - slice_k(): extracts field k of width w from a packed vector
// No ports (package).
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int WIDTH_DATA_DEF = 32;
    localparam int ADDR_W_DEF     = 5;
    localparam int NUM_WR         = 2;
    localparam int ZERO_ADDR      = 0;

    // slice_k works on a fixed-size container; callers zero-extend into it
    // and truncate the result back to the field width.
    localparam int VEC_MAX   = 256;
    localparam int SLICE_MAX = 64;

    function automatic logic [SLICE_MAX-1:0] slice_k(
        input logic [VEC_MAX-1:0] vec,
        input int                 k,
        input int                 w
    );
        logic [VEC_MAX-1:0]   v_sh;
        logic [SLICE_MAX-1:0] v_res;
        v_sh = vec >> (k * w);
        for (int i = 0; i < SLICE_MAX; i++) begin
            v_res[i] = (i < w) ? v_sh[i] : 1'b0;
        end
        return v_res;
    endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// One pending bit per register. Priority at each edge, lowest to highest:
// committed write clears < alloc sets < flush clears everything.
// Ports:
//   clock_i, reset_i   clock, async active-low reset
//   i_clr_en           per write port: committed write (clears pending)
//   i_clr_addr         packed write addresses
//   i_alloc            set pending for i_alloc_addr
//   i_alloc_addr       register claimed by a new producer
//   i_flush            clear all pending bits
//   o_pending          registered pending vector
// -----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [NUM_WR-1:0]        i_clr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_clr_addr,
    input  logic                     i_alloc,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    input  logic                     i_flush,
    output logic [2**ADDR_W-1:0]     o_pending
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_next;

    // Next-state: apply clears, then alloc (new producer supersedes), then flush.
    always_comb begin
        w_next = r_pending;
        for (int p = 0; p < NUM_WR; p++) begin
            w_next[i_clr_addr[p*ADDR_W +: ADDR_W]] =
                i_clr_en[p] ? 1'b0 : w_next[i_clr_addr[p*ADDR_W +: ADDR_W]];
        end
        w_next[i_alloc_addr] = i_alloc ? 1'b1 : w_next[i_alloc_addr];
        w_next = i_flush ? {DEPTH{1'b0}} : w_next;
    end

    // Pending-bit state register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pending <= {DEPTH{1'b0}};
        end else begin
            r_pending <= w_next;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (port 1 wins on address collision), optional hard-wired zero register,
// optional same-cycle write-to-read bypass, and a pending scoreboard.
// Ports:
//   clock_i, reset_i   clock, async active-low reset
//   rd_register_i      packed read addresses (port k at [k*ADDR_W +: ADDR_W])
//   rd_data_o          packed read data, combinational
//   rd_busy_o          pending flag of each addressed register
//   reg_write_i        write enables (bit 1 = port 1)
//   wr_register_i      packed write addresses
//   wr_data_i          packed write data
//   alloc_i            mark alloc_register_i pending at next edge
//   alloc_register_i   register claimed by a new producer
//   flush_i            clear all pending bits at next edge
// -----------------------------------------------------------------------------
module register_file_mp
    import rf_pkg::*;
#(
    parameter int WIDTH_DATA = WIDTH_DATA_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_register_i,
    output logic [NUM_RD*WIDTH_DATA-1:0] rd_data_o,
    output logic [NUM_RD-1:0]            rd_busy_o,
    input  logic [NUM_WR-1:0]            reg_write_i,
    input  logic [NUM_WR*ADDR_W-1:0]     wr_register_i,
    input  logic [NUM_WR*WIDTH_DATA-1:0] wr_data_i,
    input  logic                         alloc_i,
    input  logic [ADDR_W-1:0]            alloc_register_i,
    input  logic                         flush_i
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    logic [WIDTH_DATA-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      w_pending;
    logic [NUM_WR-1:0]     w_we;
    logic [ADDR_W-1:0]     w_wa [NUM_WR];
    logic [WIDTH_DATA-1:0] w_wd [NUM_WR];
    logic                  w_alloc;
    logic [VEC_MAX-1:0]    w_wa_vec;
    logic [VEC_MAX-1:0]    w_wd_vec;
    logic [VEC_MAX-1:0]    w_rd_vec;

    assign w_wa_vec = VEC_MAX'(wr_register_i);
    assign w_wd_vec = VEC_MAX'(wr_data_i);
    assign w_rd_vec = VEC_MAX'(rd_register_i);

    // Unpack write ports; enables are dropped while reset is held and for
    // the zero register so neither storage nor bypass ever sees them.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            w_wa[p] = ADDR_W'(slice_k(w_wa_vec, p, ADDR_W));
            w_wd[p] = WIDTH_DATA'(slice_k(w_wd_vec, p, WIDTH_DATA));
            w_we[p] = reg_write_i[p] & reset_i &
                      ~((ZERO_REG != 0) && (w_wa[p] == ZERO_A));
        end
    end

    assign w_alloc = alloc_i & reset_i &
                     ~((ZERO_REG != 0) && (alloc_register_i == ZERO_A));

    // Storage; port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= {WIDTH_DATA{1'b0}};
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_we[p]) begin
                    r_regs[w_wa[p]] <= w_wd[p];
                end
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .i_clr_en     (w_we),
        .i_clr_addr   (wr_register_i),
        .i_alloc      (w_alloc),
        .i_alloc_addr (alloc_register_i),
        .i_flush      (flush_i),
        .o_pending    (w_pending)
    );

    // Read muxes with optional bypass; a forwarded write hides the pending
    // bit because the value being read is already the producer's result.
    always_comb begin
        logic [ADDR_W-1:0]     v_addr;
        logic [WIDTH_DATA-1:0] v_data;
        logic                  v_busy;
        logic                  v_hit;
        logic                  v_zero;
        rd_data_o = {(NUM_RD*WIDTH_DATA){1'b0}};
        rd_busy_o = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            v_addr = ADDR_W'(slice_k(w_rd_vec, k, ADDR_W));
            v_data = r_regs[v_addr];
            v_busy = w_pending[v_addr];
            for (int p = 0; p < NUM_WR; p++) begin
                v_hit  = (BYPASS != 0) && w_we[p] && (w_wa[p] == v_addr);
                v_data = v_hit ? w_wd[p] : v_data;
                v_busy = v_hit ? 1'b0 : v_busy;
            end
            v_zero = (ZERO_REG != 0) && (v_addr == ZERO_A);
            rd_data_o[k*WIDTH_DATA +: WIDTH_DATA] = v_zero ? {WIDTH_DATA{1'b0}} : v_data;
            rd_busy_o[k] = v_zero ? 1'b0 : v_busy;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// -----------------------------------------------------------------------------
// tb_register_file_mp
// Two instances share all inputs: dut_a (BYPASS=1, ZERO_REG=1) and
// dut_b (BYPASS=0, ZERO_REG=0). Inputs change on the falling edge and
// outputs are sampled 2 ns later, i.e. the values seen during that cycle
// before the next rising edge commits it.
// -----------------------------------------------------------------------------
module tb_register_file_mp;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra0, ra1;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        alloc;
    logic [4:0]  aa;
    logic        flush;

    logic [63:0] rd_a, rd_b;
    logic [1:0]  busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_mp #(
        .WIDTH_DATA (32), .ADDR_W (5), .NUM_RD (2), .ZERO_REG (1), .BYPASS (1)
    ) dut_a (
        .clock_i          (clk),
        .reset_i          (rst_n),
        .rd_register_i    ({ra1, ra0}),
        .rd_data_o        (rd_a),
        .rd_busy_o        (busy_a),
        .reg_write_i      (we),
        .wr_register_i    ({wa1, wa0}),
        .wr_data_i        ({wd1, wd0}),
        .alloc_i          (alloc),
        .alloc_register_i (aa),
        .flush_i          (flush)
    );

    register_file_mp #(
        .WIDTH_DATA (32), .ADDR_W (5), .NUM_RD (2), .ZERO_REG (0), .BYPASS (0)
    ) dut_b (
        .clock_i          (clk),
        .reset_i          (rst_n),
        .rd_register_i    ({ra1, ra0}),
        .rd_data_o        (rd_b),
        .rd_busy_o        (busy_b),
        .reg_write_i      (we),
        .wr_register_i    ({wa1, wa0}),
        .wr_data_i        ({wd1, wd0}),
        .alloc_i          (alloc),
        .alloc_register_i (aa),
        .flush_i          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic        alloc;
        logic [4:0]  aa;
        logic        flush;
        logic [31:0] ea0, ea1;
        logic [1:0]  eba;
        logic [31:0] eb0, eb1;
        logic [1:0]  ebb;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we = 2'b00; wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h0; wd1 = 32'h0;
        alloc = 1'b0; aa = 5'd0; flush = 1'b0;
    endtask

    initial begin
        // we, wa0, wa1, wd0, wd1, ra0, ra1, alloc, aa, flush,
        // A: d0, d1, busy   B: d0, d1, busy
        tbl[0]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd31, 1'b0, 5'd0, 1'b0,
                    32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[1]  = '{2'b11, 5'd2, 5'd2, 32'h55555555, 32'hAAAAAAAA, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0,
                    32'hAAAAAAAA, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[2]  = '{2'b11, 5'd3, 5'd4, 32'h11111111, 32'h22222222, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0,
                    32'hAAAAAAAA, 32'h11111111, 2'b00, 32'hAAAAAAAA, 32'h0, 2'b00};
        tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0,
                    32'h11111111, 32'h22222222, 2'b00, 32'h11111111, 32'h22222222, 2'b00};
        tbl[4]  = '{2'b01, 5'd5, 5'd0, 32'h12345678, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0,
                    32'h12345678, 32'h12345678, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[5]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd5, 5'd0, 1'b1, 5'd0, 1'b0,
                    32'h12345678, 32'h0, 2'b00, 32'h12345678, 32'h0, 2'b00};
        tbl[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0,
                    32'h0, 32'h0, 2'b00, 32'hFFFFFFFF, 32'h0, 2'b01};
        tbl[7]  = '{2'b10, 5'd0, 5'd7, 32'h0, 32'hCAFEF00D, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0,
                    32'hCAFEF00D, 32'h0, 2'b00, 32'h0, 32'hFFFFFFFF, 2'b11};
        tbl[8]  = '{2'b01, 5'd7, 5'd0, 32'h0BADBEEF, 32'h0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0,
                    32'h0BADBEEF, 32'h0BADBEEF, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00};
        tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0,
                    32'h0BADBEEF, 32'h0BADBEEF, 2'b11, 32'h0BADBEEF, 32'h0BADBEEF, 2'b11};
        tbl[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0,
                    32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd9, 1'b1, 5'd9, 1'b0,
                    32'h0, 32'h0, 2'b01, 32'h0, 32'h0, 2'b01};
        tbl[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd10, 1'b1, 5'd10, 1'b0,
                    32'h0, 32'h0, 2'b01, 32'h0, 32'h0, 2'b01};
        tbl[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd10, 5'd11, 1'b1, 5'd11, 1'b1,
                    32'h0, 32'h0, 2'b01, 32'h0, 32'h0, 2'b01};
        tbl[14] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd11, 1'b0, 5'd0, 1'b0,
                    32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[15] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd10, 1'b0, 5'd0, 1'b0,
                    32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[16] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd2, 1'b0, 5'd0, 1'b0,
                    32'h0BADBEEF, 32'hAAAAAAAA, 2'b00, 32'h0BADBEEF, 32'hAAAAAAAA, 2'b00};

        // Reset held for 14 ns, then every address must read zero and idle.
        rst_n = 1'b0;
        ra0 = 5'd0; ra1 = 5'd0;
        idle_inputs();
        #14;
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a);
            ra1 = 5'(31 - a);
            #1;
            check("reset_data_a", rd_a[31:0], 32'h0);
            check("reset_data_b", rd_b[63:32], 32'h0);
            check("reset_busy", {30'd0, busy_a | busy_b}, 32'h0);
        end

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            we = tbl[i].we; wa0 = tbl[i].wa0; wa1 = tbl[i].wa1;
            wd0 = tbl[i].wd0; wd1 = tbl[i].wd1;
            ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
            alloc = tbl[i].alloc; aa = tbl[i].aa; flush = tbl[i].flush;
            #2;
            check($sformatf("v%0d_a_rd0", i), rd_a[31:0], tbl[i].ea0);
            check($sformatf("v%0d_a_rd1", i), rd_a[63:32], tbl[i].ea1);
            check($sformatf("v%0d_a_busy", i), {30'd0, busy_a}, {30'd0, tbl[i].eba});
            check($sformatf("v%0d_b_rd0", i), rd_b[31:0], tbl[i].eb0);
            check($sformatf("v%0d_b_rd1", i), rd_b[63:32], tbl[i].eb1);
            check($sformatf("v%0d_b_busy", i), {30'd0, busy_b}, {30'd0, tbl[i].ebb});
        end

        // Mid-run reset: commit r1, then assert reset with a write+alloc in flight.
        @(negedge clk);
        idle_inputs();
        we = 2'b01; wa0 = 5'd1; wd0 = 32'h55555555;
        ra0 = 5'd1; ra1 = 5'd2;
        @(negedge clk);
        idle_inputs();
        #2;
        check("r1_written_a", rd_a[31:0], 32'h55555555);
        check("r1_written_b", rd_b[31:0], 32'h55555555);
        we = 2'b01; wa0 = 5'd1; wd0 = 32'h77777777; alloc = 1'b1; aa = 5'd1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_r1_a", rd_a[31:0], 32'h0);
        check("rst_r1_b", rd_b[31:0], 32'h0);
        check("rst_r2_a", rd_a[63:32], 32'h0);
        check("rst_busy", {30'd0, busy_a | busy_b}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        #2;
        check("post_rst_r1_a", rd_a[31:0], 32'h0);
        check("post_rst_r1_b", rd_b[31:0], 32'h0);
        check("post_rst_busy", {30'd0, busy_a | busy_b}, 32'h0);
        @(negedge clk);
        #2;
        check("post_rst_r1_b_late", rd_b[31:0], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read register file used by the core datapath.
- Provides NUM_RD combinational read ports and two write ports with fixed priority.
- Optional x0-hardwired-zero and optional write-to-read bypass.
- Per-register pending (scoreboard) bits let the issue stage detect read-after-write hazards against in-flight producers.

Parameters:
- WIDTH_DATA, 32, register data width in bits (>=8).
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and allocs.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clock_i  in  1  single clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset; state clears immediately on assertion; deassertion is synchronous to clock_i.
- rd_register_i  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*WIDTH_DATA  packed read data, combinational.
- rd_busy_o  out  NUM_RD  per-port pending flag for the addressed register.
- reg_write_i  in  2  write enables; bit 1 = port 1.
- wr_register_i  in  2*ADDR_W  packed write addresses.
- wr_data_i  in  2*WIDTH_DATA  packed write data.
- alloc_i  in  1  mark alloc_register_i pending at next edge.
- alloc_register_i  in  ADDR_W  register being claimed by a new producer.
- flush_i  in  1  clear all pending bits at next edge.

Behaviour:
- Reset (reset_i=0):
  - All registers and pending bits go to 0 asynchronously.
  - rd_data_o reads 0 for every address; rd_busy_o=0.
  - Inputs are ignored while reset is held.
  - Reset asserted mid-cycle discards any write or alloc that has not yet reached an edge.
- Write:
  - On the rising edge, reg_write_i[p] stores wr_data_i[p] at wr_register_i[p].
  - Both ports to the same address: port 1 wins, port 0 is dropped.
  - Different addresses: both are written.
- Zero register (ZERO_REG=1):
  - Writes and allocs to address 0 are ignored.
  - Reads of address 0 return 0 with busy=0, even when BYPASS=1.
- Read (combinational, zero latency):
  - rd_data_o[k] = reg[rd_register_i[k]].
  - BYPASS=1: if a write enable is active to the same address (and the address is not zero-gated), the read returns that wr_data_i. Port 1 takes precedence over port 0.
  - BYPASS=0: the new value is visible the cycle after the write edge.
- Pending scoreboard (per-register bit):
  - alloc_i sets the bit at the edge.
  - Any committed write to the address clears it.
  - Alloc and write to the same address in the same cycle: alloc wins, bit = 1 (a new producer supersedes the old one).
  - flush_i clears all bits and overrides a same-cycle alloc. Register data is unaffected by flush.
- rd_busy_o[k]:
  - Equals pending[rd_register_i[k]].
  - BYPASS=1: forced 0 when a same-cycle write to that address is being forwarded.
  - BYPASS=0: no forcing.
- Addresses wrap naturally within ADDR_W; there is no out-of-range case.
- No X on outputs after reset under any legal input.

Decomposition:
- Shared package `rf_pkg`: WIDTH_DATA and ADDR_W defaults, NUM_WR=2, ZERO_ADDR constant, and a function that extracts packed slice k.
- One sub-module, `rf_scoreboard`: pending-bit array with alloc/clear/flush priority logic, parametrised on ADDR_W.
- Storage, write arbitration and the read/bypass muxes stay in the top level.

Test Plan:
- Reset: hold reset_i=0 for 14 ns, then release → every address reads 0x00000000, all rd_busy_o=0. Assert reset_i mid-run after writing 0x55555555 to r1 → r1 reads 0 immediately.
- Dual write, same address: port 0 writes 0x55555555 and port 1 writes 0xAAAAAAAA, both to r2 → next cycle r2=0xAAAAAAAA. Different addresses r3/r4 → both values stored.
- Bypass: with BYPASS=1, write 0x12345678 to r5 while port 0 reads r5 → rd_data_o same cycle = 0x12345678. With BYPASS=0, the same stimulus returns the old value 0 that cycle and 0x12345678 the next.
- Zero register: write 0xFFFFFFFF and alloc to r0 → r0 reads 0 and busy=0 at all times; also with ZERO_REG=0 → r0 reads 0xFFFFFFFF.
- Scoreboard: alloc r7 → rd_busy=1 on the next cycle. Write r7 with BYPASS=1 → busy reads 0 in the write cycle and stays 0 after. Alloc plus write r7 in the same cycle → busy=1 afterwards.
- Flush: alloc r8, r9, r10 on successive cycles, then assert flush_i together with alloc r11 → all four busy bits read 0; register data is unchanged.
